// File: rtl/axi4lite_ram_slave_if.sv
// AXI4-Lite channel bundle between a master port and the RAM responder.
// Channel names mirror the master side so the two connect one-to-one.
interface axi4lite_ram_slave_if;
   logic        AWvalid;
   logic [31:0] AWdata;
   logic [2:0]  AWprot;
   logic        AWready;
   logic        Wvalid;
   logic [31:0] Wdata;
   logic [3:0]  Wstrb;
   logic        Wready;
   logic        Bvalid;
   logic        Bready;
   logic        ARvalid;
   logic [31:0] ARdata;
   logic [2:0]  ARprot;
   logic        ARready;
   logic        Rvalid;
   logic [31:0] Rdata;
   logic        RReady;

   modport master (
      output AWvalid, AWdata, AWprot, input AWready,
      output Wvalid, Wdata, Wstrb, input Wready,
      input Bvalid, output Bready,
      output ARvalid, ARdata, ARprot, input ARready,
      input Rvalid, Rdata, output RReady
   );

   modport slave (
      input AWvalid, AWdata, AWprot, output AWready,
      input Wvalid, Wdata, Wstrb, output Wready,
      output Bvalid, input Bready,
      input ARvalid, ARdata, ARprot, output ARready,
      output Rvalid, Rdata, input RReady
   );
endinterface

// File: rtl/axi4lite_ram_slave.sv
// AXI4-Lite responder over a word-organised RAM: independent AW/W capture,
// byte-masked commit, single-beat reads with one cycle of RAM latency.
module axi4lite_ram_slave #(
   parameter int          MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic               clk,
   input logic               rst,
   axi4lite_ram_slave_if.slave s
);
   localparam int         IW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;

   logic [31:0] mem [MEM_WORDS];

   wstate_t     wst;
   rstate_t     rst_q;
   logic [31:0] aw_addr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [31:0] rdata;

   logic        aw_hs, w_hs, ar_hs;
   logic        c_fire, c_in, r_in;
   logic [31:0] c_addr, c_data;
   logic [3:0]  c_strb;
   logic [32:0] c_off, r_off;
   logic [IW-1:0] c_idx, r_idx;
   logic        unused;

   assign s.AWready = awready;
   assign s.Wready  = wready;
   assign s.Bvalid  = bvalid;
   assign s.ARready = arready;
   assign s.Rvalid  = rvalid;
   assign s.Rdata   = rdata;

   assign aw_hs = s.AWvalid & awready;
   assign w_hs  = s.Wvalid & wready;
   assign ar_hs = s.ARvalid & arready;

   // Commit uses whichever half was latched earlier plus the half arriving now.
   always_comb begin
      c_addr = (wst == W_HAVE_ADDR) ? aw_addr_q : s.AWdata;
      c_data = (wst == W_HAVE_DATA) ? wdata_q : s.Wdata;
      c_strb = (wst == W_HAVE_DATA) ? wstrb_q : s.Wstrb;
      c_fire = ((wst == W_IDLE) && aw_hs && w_hs) ||
               ((wst == W_HAVE_ADDR) && w_hs) ||
               ((wst == W_HAVE_DATA) && aw_hs);
   end

   // 33-bit offsets: a borrow in bit 32 means the address is below the base.
   assign c_off = {1'b0, c_addr} - {1'b0, BASE_ADDR};
   assign r_off = {1'b0, s.ARdata} - {1'b0, BASE_ADDR};
   assign c_in  = !c_off[32] && (c_off < SPAN);
   assign r_in  = !r_off[32] && (r_off < SPAN);
   assign c_idx = c_off[IW+1:2];
   assign r_idx = r_off[IW+1:2];

   assign unused = ^{s.AWprot, s.ARprot, c_off, r_off};

   always_ff @(posedge clk) begin
      if (!rst && c_fire && c_in) begin
         for (int b = 0; b < 4; b++) begin
            if (c_strb[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wst       <= W_IDLE;
         awready   <= 1'b0;
         wready    <= 1'b0;
         bvalid    <= 1'b0;
         aw_addr_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (wst)
            W_IDLE: begin
               if (aw_hs && w_hs) begin
                  wst     <= W_RESP;
                  awready <= 1'b0;
                  wready  <= 1'b0;
                  bvalid  <= 1'b1;
               end else if (aw_hs) begin
                  aw_addr_q <= s.AWdata;
                  wst       <= W_HAVE_ADDR;
                  awready   <= 1'b0;
                  wready    <= 1'b1;
               end else if (w_hs) begin
                  wdata_q <= s.Wdata;
                  wstrb_q <= s.Wstrb;
                  wst     <= W_HAVE_DATA;
                  awready <= 1'b1;
                  wready  <= 1'b0;
               end else begin
                  // Also the first cycle out of reset, when readies are still low.
                  awready <= 1'b1;
                  wready  <= 1'b1;
               end
            end
            W_HAVE_ADDR: begin
               if (w_hs) begin
                  wst    <= W_RESP;
                  wready <= 1'b0;
                  bvalid <= 1'b1;
               end
            end
            W_HAVE_DATA: begin
               if (aw_hs) begin
                  wst     <= W_RESP;
                  awready <= 1'b0;
                  bvalid  <= 1'b1;
               end
            end
            W_RESP: begin
               if (s.Bready) begin
                  wst     <= W_IDLE;
                  bvalid  <= 1'b0;
                  awready <= 1'b1;
                  wready  <= 1'b1;
               end
            end
            default: wst <= W_IDLE;
         endcase
      end
   end

   // Non-blocking RAM read returns pre-write contents on a same-edge commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q   <= R_IDLE;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
      end else begin
         case (rst_q)
            R_IDLE: begin
               if (ar_hs) begin
                  rdata   <= r_in ? mem[r_idx] : 32'h0;
                  rvalid  <= 1'b1;
                  arready <= 1'b0;
                  rst_q   <= R_DATA;
               end else begin
                  arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (s.RReady) begin
                  rvalid  <= 1'b0;
                  arready <= 1'b1;
                  rst_q   <= R_IDLE;
               end
            end
            default: rst_q <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4lite_ram_slave.sv
// Randomized bench for axi4lite_ram_slave against a flag/array reference model,
// plus directed scenarios with hand-computed expectations.
module tb_axi4lite_ram_slave;
   localparam int          MW   = 64;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi4lite_ram_slave_if bus();

   axi4lite_ram_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
      .clk(clk),
      .rst(rst),
      .s  (bus)
   );

   int passed = 0;
   int total  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: memory array plus "what is pending" flags.
   logic [31:0] mm [MW];
   bit          started, rdy_en, have_aw, have_w, b_owed, r_owed;
   bit          awr_m, wr_m, arr_m;
   logic [31:0] pa, pd, exp_rdata;
   logic [3:0]  ps;
   int          k;

   function automatic bit in_rng(input logic [31:0] a);
      longint unsigned ua = {32'h0, a};
      longint unsigned ub = {32'h0, BASE};
      return (ua >= ub) && (ua < ub + 64'(4 * MW));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         started = 1; rdy_en = 0; have_aw = 0; have_w = 0;
         b_owed = 0; r_owed = 0; exp_rdata = 32'h0;
      end else begin
         awr_m = rdy_en && !have_aw && !b_owed;
         wr_m  = rdy_en && !have_w && !b_owed;
         arr_m = rdy_en && !r_owed;
         if (b_owed && bus.Bready) b_owed = 0;
         if (r_owed && bus.RReady) r_owed = 0;
         if (bus.ARvalid && arr_m) begin
            exp_rdata = in_rng(bus.ARdata) ? mm[widx(bus.ARdata)] : 32'h0;
            r_owed = 1;
         end
         if (bus.AWvalid && awr_m) begin pa = bus.AWdata; have_aw = 1; end
         if (bus.Wvalid && wr_m) begin pd = bus.Wdata; ps = bus.Wstrb; have_w = 1; end
         if (have_aw && have_w) begin
            if (in_rng(pa)) begin
               k = widx(pa);
               for (int b = 0; b < 4; b++) if (ps[b]) mm[k][8*b +: 8] = pd[8*b +: 8];
            end
            have_aw = 0; have_w = 0; b_owed = 1;
         end
         rdy_en = 1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("AWready", 32'(bus.AWready), 32'(rdy_en && !have_aw && !b_owed));
         check("Wready",  32'(bus.Wready),  32'(rdy_en && !have_w && !b_owed));
         check("ARready", 32'(bus.ARready), 32'(rdy_en && !r_owed));
         check("Bvalid",  32'(bus.Bvalid),  32'(b_owed));
         check("Rvalid",  32'(bus.Rvalid),  32'(r_owed));
         check("Rdata",   bus.Rdata, exp_rdata);
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int aw_t, input int w_t, input int b_hold);
      bit awd = 0;
      bit wd  = 0;
      int t   = 0;
      while (!(awd && wd) && t < 40) begin
         @(negedge clk);
         bus.AWvalid = !awd && (t >= aw_t);
         bus.AWdata  = a;
         bus.Wvalid  = !wd && (t >= w_t);
         bus.Wdata   = d;
         bus.Wstrb   = s;
         if (bus.AWvalid && bus.AWready) awd = 1;
         if (bus.Wvalid && bus.Wready) wd = 1;
         t++;
      end
      check("wr accept", 32'(awd && wd), 32'h1);
      @(negedge clk);
      bus.AWvalid = 0;
      bus.Wvalid  = 0;
      t = 0;
      while (!bus.Bvalid && t < 20) begin @(negedge clk); t++; end
      check("wr bvalid", 32'(bus.Bvalid), 32'h1);
      repeat (b_hold) begin
         @(negedge clk);
         check("bp Bvalid", 32'(bus.Bvalid), 32'h1);
         check("bp AWready", 32'(bus.AWready), 32'h0);
         check("bp Wready", 32'(bus.Wready), 32'h0);
      end
      bus.Bready = 1;
      @(negedge clk);
      bus.Bready = 0;
   endtask

   task automatic rd(input logic [31:0] a, input int r_hold, output logic [31:0] d);
      int t = 0;
      @(negedge clk);
      bus.ARvalid = 1;
      bus.ARdata  = a;
      while (!bus.ARready && t < 20) begin @(negedge clk); t++; end
      check("rd accept", 32'(bus.ARready), 32'h1);
      @(negedge clk);
      bus.ARvalid = 0;
      check("rd latency", 32'(bus.Rvalid), 32'h1);
      d = bus.Rdata;
      repeat (r_hold) begin
         @(negedge clk);
         check("bp Rvalid", 32'(bus.Rvalid), 32'h1);
         check("bp ARready", 32'(bus.ARready), 32'h0);
         check("bp Rdata", bus.Rdata, d);
      end
      bus.RReady = 1;
      @(negedge clk);
      bus.RReady = 0;
   endtask

   function automatic logic [31:0] pick_addr();
      int r = int'($urandom_range(0, 19));
      if (r < 16) return BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
      if (r == 16) return BASE + 32'(4 * (MW - 1));
      if (r == 17) return BASE + 32'(4 * MW);
      if (r == 18) return BASE - 32'h4;
      return 32'hFFFF_FFFC;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      bus.AWvalid = 0; bus.AWdata = 0; bus.AWprot = 0;
      bus.Wvalid = 0; bus.Wdata = 0; bus.Wstrb = 0; bus.Bready = 0;
      bus.ARvalid = 0; bus.ARdata = 0; bus.ARprot = 0; bus.RReady = 0;
      repeat (3) @(negedge clk);
      check("reset AWready", 32'(bus.AWready), 32'h0);
      check("reset Rdata", bus.Rdata, 32'h0);
      rst = 0;
      @(negedge clk);
      check("post-reset ARready", 32'(bus.ARready), 32'h1);

      for (int i = 0; i < 16; i++) wr(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);
      wr(BASE + 32'(4 * (MW - 1)), $urandom, 4'hF, 0, 0, 0);

      // Same-cycle AW+W, Bvalid exactly one cycle later for one cycle.
      @(negedge clk);
      bus.AWvalid = 1; bus.AWdata = BASE + 32'h10;
      bus.Wvalid = 1; bus.Wdata = 32'hDEADBEEF; bus.Wstrb = 4'hF;
      check("t1 AWready", 32'(bus.AWready), 32'h1);
      @(negedge clk);
      bus.AWvalid = 0; bus.Wvalid = 0;
      check("t1 Bvalid N+1", 32'(bus.Bvalid), 32'h1);
      bus.Bready = 1;
      @(negedge clk);
      bus.Bready = 0;
      check("t1 Bvalid drop", 32'(bus.Bvalid), 32'h0);
      rd(BASE + 32'h10, 0, d);
      check("t1 readback", d, 32'hDEADBEEF);

      // Split channels, W first then AW first.
      wr(BASE + 32'h4, 32'h11223344, 4'hF, 3, 0, 0);
      rd(BASE + 32'h4, 0, d);
      check("W-first readback", d, 32'h11223344);
      wr(BASE + 32'h4, 32'h0, 4'hF, 0, 0, 0);
      wr(BASE + 32'h4, 32'h11223344, 4'hF, 0, 3, 0);
      rd(BASE + 32'h4, 0, d);
      check("AW-first readback", d, 32'h11223344);

      // Byte strobes.
      wr(BASE + 32'hC, 32'hAABBCCDD, 4'hF, 0, 0, 0);
      wr(BASE + 32'hC, 32'h00001122, 4'b0011, 0, 0, 0);
      rd(BASE + 32'hC, 0, d);
      check("strobe 0011", d, 32'hAABB1122);
      wr(BASE + 32'hC, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
      rd(BASE + 32'hC, 0, d);
      check("strobe 0000", d, 32'hAABB1122);

      // Backpressure on both channels.
      wr(BASE + 32'h14, 32'h55, 4'hF, 0, 0, 5);
      rd(BASE + 32'h14, 5, d);
      check("bp readback", d, 32'h55);

      // Out of range, then same-edge write/read collision.
      rd(BASE + 32'(4 * MW), 0, d);
      check("oob high", d, 32'h0);
      rd(BASE - 32'h4, 0, d);
      check("oob low", d, 32'h0);
      wr(BASE + 32'h8, 32'h5, 4'hF, 0, 0, 0);
      @(negedge clk);
      bus.AWvalid = 1; bus.AWdata = BASE + 32'h8;
      bus.Wvalid = 1; bus.Wdata = 32'h9; bus.Wstrb = 4'hF;
      bus.ARvalid = 1; bus.ARdata = BASE + 32'h8;
      @(negedge clk);
      bus.AWvalid = 0; bus.Wvalid = 0; bus.ARvalid = 0;
      check("collision old", bus.Rdata, 32'h5);
      bus.Bready = 1; bus.RReady = 1;
      @(negedge clk);
      bus.Bready = 0; bus.RReady = 0;
      rd(BASE + 32'h8, 0, d);
      check("collision new", d, 32'h9);

      // Reset with AW latched and W pending.
      wr(BASE + 32'h20, 32'h12345678, 4'hF, 0, 0, 0);
      @(negedge clk);
      bus.AWvalid = 1; bus.AWdata = BASE + 32'h20;
      @(negedge clk);
      bus.AWvalid = 0;
      check("rst-mid AWready", 32'(bus.AWready), 32'h0);
      rst = 1;
      bus.Wvalid = 1; bus.Wdata = 32'hFFFFFFFF; bus.Wstrb = 4'hF;
      @(negedge clk);
      check("in rst Wready", 32'(bus.Wready), 32'h0);
      check("in rst ARready", 32'(bus.ARready), 32'h0);
      @(negedge clk);
      rst = 0;
      bus.Wvalid = 0;
      @(negedge clk);
      check("after rst AWready", 32'(bus.AWready), 32'h1);
      check("after rst Wready", 32'(bus.Wready), 32'h1);
      repeat (3) begin
         @(negedge clk);
         check("after rst Bvalid", 32'(bus.Bvalid), 32'h0);
      end
      rd(BASE + 32'h20, 0, d);
      check("rst word kept", d, 32'h12345678);

      // Randomized traffic, sometimes with both channels active together.
      for (int n = 0; n < 200; n++) begin
         int op = int'($urandom_range(0, 2));
         if (op == 0) begin
            wr(pick_addr(), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end else if (op == 1) begin
            rd(pick_addr(), int'($urandom_range(0, 3)), d);
         end else begin
            logic [31:0] d2;
            fork
               wr(pick_addr(), $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
               rd(pick_addr(), int'($urandom_range(0, 2)), d2);
            join
         end
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/axi4lite_ram_slave.md
# axi4lite_ram_slave

AXI4-Lite responder backed by a word-organised on-chip RAM; the slave-side counterpart of the core's AXI4-Lite master port. Accepts write address/data independently, commits byte-masked writes, returns a write acknowledge, and serves single-beat reads with one cycle of RAM latency. Ports mirror the master's channel names so the two connect one-to-one in SoC and testbench tops.

## Interface
- MEM_WORDS, 1024: RAM depth in 32-bit words (power of two not required).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- AWvalid  in  1  write address valid.
- AWdata  in  32  write byte address.
- AWprot  in  3  protection; accepted and ignored.
- AWready  out  1  write address accepted.
- Wvalid  in  1  write data valid.
- Wdata  in  32  write data.
- Wstrb  in  4  byte enables; bit n gates Wdata[8n+7:8n].
- Wready  out  1  write data accepted.
- Bvalid  out  1  write acknowledge valid.
- Bready  in  1  master accepts acknowledge.
- ARvalid  in  1  read address valid.
- ARdata  in  32  read byte address.
- ARprot  in  3  protection; accepted and ignored.
- ARready  out  1  read address accepted.
- Rvalid  out  1  read data valid.
- Rdata  out  32  read data.
- RReady  in  1  master accepts read data.

## Operation
- Address decode: in range iff BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS; index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
- Write FSM states: W_IDLE, W_HAVE_ADDR (AW captured, waiting W), W_HAVE_DATA (W captured, waiting AW), W_RESP.
  - W_IDLE: AWready=1, Wready=1. AW and W same cycle -> commit write, go W_RESP. AW only -> latch address, W_HAVE_ADDR. W only -> latch Wdata/Wstrb, W_HAVE_DATA.
  - W_HAVE_ADDR: AWready=0, Wready=1; on Wvalid -> commit, W_RESP.
  - W_HAVE_DATA: AWready=1, Wready=0; on AWvalid -> commit, W_RESP.
  - W_RESP: AWready=0, Wready=0, Bvalid=1; on Bready -> W_IDLE.
- Commit: on the accepting edge, each byte with Wstrb bit set is written to RAM[index]; out-of-range or Wstrb=0 writes are dropped but still acknowledged.
- Read FSM states: R_IDLE (ARready=1, Rvalid=0), R_DATA (ARready=0, Rvalid=1).
  - R_IDLE: ARvalid -> Rdata <= RAM[index] (0x0000_0000 if out of range), R_DATA.
  - R_DATA: Rdata held stable; on RReady -> R_IDLE.
- Read and write channels run concurrently and independently.
- Same-cycle read accept and write commit to the same word: read returns pre-write contents.

## Timing
- Reset (rst high at an edge): both FSMs to idle; Bvalid=0, Rvalid=0, Rdata=0; AWready, Wready, ARready forced 0 while rst is high, rise the cycle after release. RAM contents not reset.
- Reset mid-transaction: pending latched address/data discarded, no write committed unless its commit edge preceded reset, no Bvalid/Rvalid issued afterward.
- Write latency: AW+W accepted edge N -> RAM updated at edge N, Bvalid high from N+1. Min write period 2 cycles (Bready held high).
- Read latency: AR accepted edge N -> Rvalid and Rdata valid from N+1. Min read period 2 cycles.
- Valid outputs never drop without the matching ready; Bvalid/Rvalid independent of master valids once raised.
- Ready outputs are decoded from registered state only (no combinational path from any input).

## Test plan
- Full write then read: AW=BASE+0x10, W=0xDEADBEEF, Wstrb=4'hF same cycle, Bready=1 -> Bvalid one cycle later for one cycle; AR=BASE+0x10 -> Rdata=0xDEADBEEF, Rvalid one cycle after ARready handshake.
- Split/ordered channels: W=0x11223344 three cycles before AW=BASE+0x4 -> W_HAVE_DATA, commit on AW edge; repeat with AW first; read back 0x11223344 both orders.
- Byte strobes: word holds 0xAABBCCDD, write 0x00001122 Wstrb=4'b0011 -> read 0xAABB1122; Wstrb=0 -> unchanged, Bvalid still issued.
- Backpressure: hold Bready=0 and RReady=0 for 5 cycles -> Bvalid/Rvalid/Rdata stable, AWready/Wready/ARready stay 0; release -> idle next cycle.
- Out of range + collision: AR at BASE+4*MEM_WORDS -> Rdata=0; write to BASE+0x8 (old 0x5, new 0x9) with same-cycle read of BASE+0x8 -> read returns 0x5, next read 0x9.
- Reset mid-write: AW accepted, W pending, rst pulsed -> no Bvalid, word unchanged, readies 0 during rst and 1 the cycle after.
